// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the buffered UART loopback block.
package uart_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO = 2'b00,
        MODE_FLIP = 2'b01,
        MODE_HOLD = 2'b10,
        MODE_DROP = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        LED_LAST_RX  = 2'b00,
        LED_RX_COUNT = 2'b01,
        LED_LEVEL    = 2'b10,
        LED_STATUS   = 2'b11
    } led_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } tx_state_e;

    // Swap case of ASCII letters; every other byte passes through.
    function automatic logic [7:0] case_flip(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b ^ 8'h20;
        return b;
    endfunction

endpackage

// File: rtl/uart_loopback_buffered_fifo.sv
// Synchronous byte FIFO with first-word fall-through head and a 0..DEPTH level.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_loopback_buffered.sv
// FIFO-decoupled UART loopback with data modes, overflow flag, counters and LED debug views.
//   state | meaning
//   IDLE  | waiting for a queued byte, transmitter free and mode not hold
//   ARM   | start just issued; covers the transmitter's busy latency
//   WAIT  | transmitter busy; return to IDLE when it drops
module uart_loopback_buffered
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int LED_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_data_ready,
    input  logic [7:0]           rx_data,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic [1:0]           mode,
    input  logic [1:0]           led_sel,
    output logic [LED_WIDTH-1:0] led,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] rx_count,
    output logic [CNT_WIDTH-1:0] tx_count
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            state_q, state_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [7:0]           last_rx_q, last_rx_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] rx_count_q, rx_count_d;
    logic [CNT_WIDTH-1:0] tx_count_q, tx_count_d;
    logic [LED_WIDTH-1:0] led_q, led_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]           fifo_head;
    logic [LVL_W-1:0]     fifo_level;
    logic [31:0]          level_w;
    mode_e                mode_m;
    led_sel_e             led_sel_m;

    assign mode_m    = mode_e'(mode);
    assign led_sel_m = led_sel_e'(led_sel);
    assign level_w   = 32'(fifo_level);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (rx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !tx_busy && mode_m != MODE_HOLD) begin
                    tx_start_d = 1'b1;
                    fifo_pop   = 1'b1;
                    state_d    = ST_ARM;
                end
            end
            ST_ARM:  state_d = ST_WAIT;
            ST_WAIT: if (!tx_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_push  = rx_data_ready && (mode_m != MODE_DROP);
        last_rx_d  = rx_data_ready ? rx_data : last_rx_q;
        overflow_d = overflow_q | (fifo_push & fifo_full);
        rx_count_d = rx_count_q;
        if (fifo_push && !fifo_full)
            rx_count_d = rx_count_q + CNT_WIDTH'(1);
        tx_data_d  = tx_data_q;
        tx_count_d = tx_count_q;
        if (tx_start_d) begin
            tx_data_d  = (mode_m == MODE_FLIP) ? case_flip(fifo_head) : fifo_head;
            tx_count_d = tx_count_q + CNT_WIDTH'(1);
        end
        case (led_sel_m)
            LED_LAST_RX:  led_d = last_rx_q;
            LED_RX_COUNT: led_d = rx_count_q[7:0];
            LED_LEVEL:    led_d = (level_w > 32'd255) ? 8'hFF : level_w[7:0];
            default:      led_d = {overflow_q, fifo_full, fifo_empty, 1'b0, state_q, mode};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            last_rx_q  <= '0;
            overflow_q <= 1'b0;
            rx_count_q <= '0;
            tx_count_q <= '0;
            led_q      <= '0;
        end else begin
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            last_rx_q  <= last_rx_d;
            overflow_q <= overflow_d;
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
            led_q      <= led_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign rx_count = rx_count_q;
    assign tx_count = tx_count_q;
    assign led      = led_q;

endmodule

// File: tb/tb_uart_loopback_buffered.sv
// Directed bench for uart_loopback_buffered with a behavioural transmitter busy model.
module tb_uart_loopback_buffered;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_data_ready;
    logic [7:0]  rx_data;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  mode;
    logic [1:0]  led_sel;
    logic [7:0]  led;
    logic        overflow;
    logic [15:0] rx_count;
    logic [15:0] tx_count;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    int start_while_busy = 0;
    logic [7:0] txq[$];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    uart_loopback_buffered dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data_ready (rx_data_ready),
        .rx_data       (rx_data),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .mode          (mode),
        .led_sel       (led_sel),
        .led           (led),
        .overflow      (overflow),
        .rx_count      (rx_count),
        .tx_count      (tx_count)
    );

    // Transmitter: records each started byte, goes busy one cycle after tx_start.
    always @(posedge clk) begin
        if (tx_start) begin
            txq.push_back(tx_data);
            if (tx_busy) start_while_busy++;
        end
        if (tx_start && busy_len > 0) begin
            busy_cnt <= busy_len;
            tx_busy  <= 1'b1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data       = b;
        rx_data_ready = 1'b1;
        step();
        rx_data_ready = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int bound);
        int k = 0;
        while (txq.size() < n && k < bound) begin
            step();
            k++;
        end
    endtask

    function automatic logic [7:0] qget(input int i);
        if (i < txq.size()) return txq[i];
        return 8'hxx;
    endfunction

    initial begin
        int peak;
        int n0;
        int k;

        vecs[0] = '{2'b00, 8'h41, 8'h41};
        vecs[1] = '{2'b01, 8'h61, 8'h41};
        vecs[2] = '{2'b01, 8'h5B, 8'h5B};
        vecs[3] = '{2'b01, 8'h5A, 8'h7A};
        vecs[4] = '{2'b01, 8'h40, 8'h40};
        vecs[5] = '{2'b01, 8'h7B, 8'h7B};
        vecs[6] = '{2'b01, 8'h60, 8'h60};
        vecs[7] = '{2'b00, 8'h7A, 8'h7A};
        vecs[8] = '{2'b01, 8'h7A, 8'h5A};
        vecs[9] = '{2'b01, 8'h30, 8'h30};

        rx_data_ready = 1'b0;
        rx_data       = 8'h00;
        mode          = 2'b00;
        led_sel       = 2'b00;
        do_reset();

        check("reset tx_start", 32'(tx_start), 32'(0));
        check("reset tx_data",  32'(tx_data),  32'(0));
        check("reset led",      32'(led),      32'(0));
        check("reset overflow", 32'(overflow), 32'(0));
        check("reset rx_count", 32'(rx_count), 32'(0));
        check("reset tx_count", 32'(tx_count), 32'(0));

        // Single-byte latency and transform table
        busy_len = 3;
        for (int i = 0; i < 10; i++) begin
            mode          = vecs[i].mode;
            rx_data       = vecs[i].din;
            rx_data_ready = 1'b1;
            step();
            rx_data_ready = 1'b0;
            check("vec start early", 32'(tx_start), 32'(0));
            step();
            check("vec start at +2", 32'(tx_start), 32'(1));
            check("vec tx_data",     32'(tx_data),  32'(vecs[i].dout));
            step(10);
        end
        check("table rx_count", 32'(rx_count), 32'(10));
        check("table tx_count", 32'(tx_count), 32'(10));

        // Drop mode: last-rx updates, nothing queued
        mode = 2'b11;
        n0 = txq.size();
        send(8'h55);
        step(4);
        check("drop no tx",       32'(txq.size()), 32'(n0));
        check("drop rx_count",    32'(rx_count),   32'(10));
        led_sel = 2'b00;
        step();
        check("led last rx",      32'(led), 32'(8'h55));
        led_sel = 2'b01;
        step();
        check("led rx_count",     32'(led), 32'(10));
        led_sel = 2'b11;
        step();
        check("led status idle",  32'(led), 32'(8'h23));
        check("table overflow",   32'(overflow), 32'(0));

        // Backpressure: 10 bytes every 2 cycles, 40-cycle busy
        do_reset();
        txq.delete();
        start_while_busy = 0;
        mode     = 2'b00;
        busy_len = 40;
        led_sel  = 2'b10;
        peak     = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'h10 + 8'(i));
            if (32'(led) > peak) peak = 32'(led);
            step();
            if (32'(led) > peak) peak = 32'(led);
        end
        k = 0;
        while (txq.size() < 10 && k < 1000) begin
            step();
            if (32'(led) > peak) peak = 32'(led);
            k++;
        end
        check("bp count", 32'(txq.size()), 32'(10));
        for (int i = 0; i < 10; i++)
            check("bp order", 32'(qget(i)), 32'(8'h10 + 8'(i)));
        check("bp overflow",     32'(overflow), 32'(0));
        check("bp start busy",   32'(start_while_busy), 32'(0));
        check("bp peak level>=8", 32'(peak >= 8), 32'(1));

        // Overflow in hold mode, then drain
        do_reset();
        txq.delete();
        mode     = 2'b10;
        busy_len = 3;
        led_sel  = 2'b10;
        for (int i = 0; i < 18; i++)
            send(8'h80 + 8'(i));
        step(2);
        check("ovf level",    32'(led),      32'(16));
        check("ovf flag",     32'(overflow), 32'(1));
        check("ovf rx_count", 32'(rx_count), 32'(16));
        check("ovf no tx",    32'(txq.size()), 32'(0));
        led_sel = 2'b11;
        step();
        check("ovf status",   32'(led),      32'(8'hC2));
        mode = 2'b00;
        wait_tx(16, 400);
        step(10);
        check("drain count",  32'(txq.size()), 32'(16));
        for (int i = 0; i < 16; i++)
            check("drain order", 32'(qget(i)), 32'(8'h80 + 8'(i)));
        check("drain overflow", 32'(overflow), 32'(1));
        check("drain tx_count", 32'(tx_count), 32'(16));

        // Push and pop in the same cycle at level 1
        do_reset();
        txq.delete();
        busy_len = 3;
        mode     = 2'b10;
        led_sel  = 2'b10;
        send(8'hA1);
        step(2);
        check("pp level before", 32'(led), 32'(1));
        mode          = 2'b00;
        rx_data       = 8'hA2;
        rx_data_ready = 1'b1;
        step();
        rx_data_ready = 1'b0;
        check("pp tx_start", 32'(tx_start), 32'(1));
        check("pp tx_data",  32'(tx_data),  32'(8'hA1));
        step();
        check("pp level after", 32'(led), 32'(1));
        wait_tx(2, 100);
        check("pp first",  32'(qget(0)), 32'(8'hA1));
        check("pp second", 32'(qget(1)), 32'(8'hA2));

        // Reset while in WAIT with queued bytes
        do_reset();
        txq.delete();
        mode     = 2'b00;
        busy_len = 40;
        led_sel  = 2'b10;
        for (int i = 0; i < 6; i++)
            send(8'h30 + 8'(i));
        step(3);
        check("rst level 5", 32'(led), 32'(5));
        led_sel = 2'b11;
        step();
        check("rst status wait", 32'(led), 32'(8'h08));
        led_sel = 2'b10;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        check("rst led",      32'(led),      32'(0));
        check("rst rx_count", 32'(rx_count), 32'(0));
        check("rst tx_count", 32'(tx_count), 32'(0));
        check("rst overflow", 32'(overflow), 32'(0));
        step();
        check("rst level 0",  32'(led),      32'(0));
        n0 = txq.size();
        k = 0;
        while (tx_busy && k < 100) begin
            step();
            k++;
        end
        check("rst busy falls", 32'(tx_busy), 32'(0));
        step(5);
        check("rst no start", 32'(txq.size()), 32'(n0));
        send(8'h77);
        check("rst new early", 32'(tx_start), 32'(0));
        step();
        check("rst new start", 32'(tx_start), 32'(1));
        check("rst new data",  32'(tx_data),  32'(8'h77));
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_loopback_buffered.md
Name: uart_loopback_buffered

Overview:
- Parametrised successor to the board UART loopback test.
- Sits between async_receiver and async_transmitter and decouples them with a byte FIFO, so the TX side can lag RX without losing bytes.
- Adds selectable data modes (echo, case-flip, hold, drop), a sticky overflow flag and received/transmitted byte counters.
- LEDs show one of several debug views, for baud-rate stress testing on the iCE40HX-8K board.

Parameters:
- FIFO_DEPTH, 16: FIFO entries; power of two, 2..256.
- CNT_WIDTH, 16: width of the rx_count/tx_count byte counters; 8..32.
- LED_WIDTH, 8: width of the led output; fixed at 8 in this generation.

Ports:
- clk  in  1  system clock (12 MHz on board).
- reset  in  1  synchronous, active-high reset.
- rx_data_ready  in  1  one-cycle strobe from async_receiver; rx_data valid.
- rx_data  in  8  received byte.
- tx_busy  in  1  async_transmitter busy.
- tx_start  out  1  one-cycle start strobe to async_transmitter.
- tx_data  out  8  byte to transmit; held stable from the tx_start cycle until tx_busy falls.
- mode  in  2  00 echo, 01 case-flip, 10 hold, 11 drop.
- led_sel  in  2  00 last rx byte, 01 rx_count[7:0], 10 FIFO level, 11 status.
- led  out  8  debug display.
- overflow  out  1  sticky; set when a byte arrives while the FIFO is full.
- rx_count  out  CNT_WIDTH  bytes accepted into the FIFO (wraps).
- tx_count  out  CNT_WIDTH  bytes handed to the transmitter (wraps).

Behaviour:
- Reset values: tx_start=0, tx_data=0, led=0, overflow=0, rx_count=0, tx_count=0; FIFO empty; FSM in IDLE; last-rx register 0.
- Reset is synchronous and wins over every other event in the same cycle, including mid-transmission. Bytes already in the FIFO are discarded. The transmitter is not aborted, but the FSM re-enters IDLE and waits for tx_busy low before the next start.
- RX push path:
  - On rx_data_ready, last-rx is always updated.
  - Mode 11: the byte is not pushed.
  - Otherwise, if the FIFO is not full: push, rx_count+1.
  - If full: byte dropped, overflow<=1, rx_count unchanged.
  - A push and a pop in the same cycle are both honoured; level is unchanged.
- Transform is applied at pop time:
  - Mode 01 flips bit 5 of ASCII letters only (0x41-0x5A and 0x61-0x7A).
  - All other bytes and modes pass through unchanged.
- TX FSM:
  - IDLE: if FIFO not empty, tx_busy=0 and mode≠10 → pop, latch transformed head into tx_data, tx_start=1 for one cycle, tx_count+1 → ARM.
  - ARM: one cycle that absorbs the transmitter's one-cycle busy latency; tx_busy is ignored → WAIT.
  - WAIT: while tx_busy=1 stay; when tx_busy=0 → IDLE.
  - Minimum spacing between tx_start pulses is 3 cycles.
  - Mode 10 (hold) only gates the start in IDLE. An in-flight byte completes; bytes accumulate in the FIFO.
  - Mode 11 (drop) still drains bytes already queued.
  - Mode changes take effect the next cycle.
- Latency: a byte arriving into an empty FIFO with an idle transmitter gives tx_start 2 cycles after its rx_data_ready cycle (push at edge 1, pop/start at edge 2).
- FIFO level is 0..FIFO_DEPTH, so its width is clog2(FIFO_DEPTH)+1. Full when level==FIFO_DEPTH. Read/write pointers wrap modulo FIFO_DEPTH.
- Counters wrap silently at 2^CNT_WIDTH.
- LED views (registered, 1-cycle latency from the selected source):
  - 00: last rx byte.
  - 01: rx_count[7:0].
  - 10: FIFO level saturated to 255.
  - 11: {overflow, full, empty, 1'b0, state[1:0], mode[1:0]}.
- overflow clears only on reset.

Decomposition:
- Shared package (uart_pkg): mode encodings, led_sel encodings, TX FSM state encodings (IDLE=0, ARM=1, WAIT=2), and the case-flip helper function.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH), providing push/pop/full/empty/level with registered read data presented as first-word fall-through.
- The board top instantiates async_receiver, async_transmitter and this block.

Test Plan:
- Echo single byte: reset, mode=00, send 0x41 with tx_busy model idle → tx_start exactly 2 cycles later with tx_data=0x41; tx_count=1, rx_count=1.
- Case-flip: mode=01, send 0x61,0x5B,0x5A → transmitted sequence 0x41,0x5B,0x7A.
- Backpressure/ordering: the busy model holds tx_busy for 40 cycles per byte; send 10 bytes back-to-back every 2 cycles → all 10 transmitted in order, no overflow, level peaks ≥8, tx_start never pulses while tx_busy=1.
- Overflow: mode=10, FIFO_DEPTH=16, send 18 bytes → level=16, overflow=1, rx_count=16, no tx_start. Switch to mode=00 → exactly 16 bytes drain in order; overflow stays 1.
- Simultaneous push/pop: FIFO at level 1; the rx_data_ready cycle coincides with the pop in IDLE → level stays 1 and both bytes are eventually sent in order.
- Reset mid-operation: reset asserted in WAIT with level 5 → next cycle level=0, counters 0, overflow 0, led 0. No tx_start occurs until tx_busy falls and a new byte arrives.
